interrupt_controller: RTL

Prioritised, maskable interrupt controller that sits between the eight external `interrupcion` lines and the single-cycle CPU's control unit. It latches rising edges on each line, selects the highest-priority enabled request, and presents one request at a time to the CPU through a request/acknowledge/return handshake. Along with the request it supplies a 16-bit handler vector for the program counter mux. Nesting is not supported: one interrupt is in service at a time.

---
 rtl/interrupt_pkg.sv | 24 ++
 rtl/interrupt_controller_prio.sv | 18 +
 rtl/interrupt_controller.sv | 100 ++++++++++
 3 files changed

// File: rtl/interrupt_pkg.sv
// Shared constants for the interrupt controller: FSM encoding, line count, vector defaults.
// Also holds the handler-address helper used by the top level.
package interrupt_pkg;

  localparam int N_LINES = 8;
  localparam int ID_W    = 3;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_REQ     = 2'b01;
  localparam logic [1:0] ST_SERVICE = 2'b10;

  localparam logic [15:0] VEC_BASE_DEF  = 16'h0010;
  localparam int unsigned VEC_SHIFT_DEF = 2;

  // Handler address wraps modulo 2^16 by construction of the 16-bit sum.
  function automatic logic [15:0] calc_vector(input logic [15:0] base,
                                              input logic [ID_W-1:0] id,
                                              input int unsigned shift);
    logic [15:0] offs;
    offs = 16'(id) << shift;
    return base + offs;
  endfunction

endpackage

// File: rtl/interrupt_controller_prio.sv
// Fixed-priority encoder over 8 requests; lowest set index wins. Purely combinational.
module prio_encoder_8
  import interrupt_pkg::*;
(
  input  logic [N_LINES-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Maskable, prioritised interrupt controller with req/ack/reti handshake; line rise to irq is 2 edges.
// All outputs registered; one interrupt in service at a time, further edges wait in pending.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter logic [15:0] VEC_BASE  = VEC_BASE_DEF,
  parameter int unsigned VEC_SHIFT = VEC_SHIFT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_LINES-1:0] interrupcion,
  input  logic               mask_we,
  input  logic [N_LINES-1:0] mask_wdata,
  input  logic               ack,
  input  logic               reti,
  output logic               irq,
  output logic [15:0]        vector,
  output logic [ID_W-1:0]    active_id,
  output logic               busy,
  output logic [N_LINES-1:0] pending
);

  logic [1:0]         state;
  logic [N_LINES-1:0] prev;
  logic [N_LINES-1:0] mask;
  logic [N_LINES-1:0] pend_q;
  logic [N_LINES-1:0] rise;
  logic [N_LINES-1:0] clr;
  logic [N_LINES-1:0] eligible;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;

  assign rise     = interrupcion & ~prev;
  assign eligible = pend_q & mask;
  assign pending  = pend_q;

  // Clear only the in-service line on ack; a coincident new edge on it re-sets it.
  always_comb begin
    clr = '0;
    if (state == ST_REQ && ack) clr[active_id] = 1'b1;
  end

  prio_encoder_8 u_prio (
    .req   (eligible),
    .valid (win_vld),
    .idx   (win_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev   <= '0;
      mask   <= '0;
      pend_q <= '0;
    end else begin
      prev   <= interrupcion;
      pend_q <= (pend_q & ~clr) | rise;
      if (mask_we) mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      irq       <= 1'b0;
      busy      <= 1'b0;
      active_id <= '0;
      vector    <= VEC_BASE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            state     <= ST_REQ;
            irq       <= 1'b1;
            active_id <= win_id;
            vector    <= calc_vector(VEC_BASE, win_id, VEC_SHIFT);
          end
        end
        ST_REQ: begin
          if (ack) begin
            state <= ST_SERVICE;
            irq   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (reti) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          irq   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
